// File: rtl/dma_timing_ctrl_mc.sv
// ---------------------------------------------------------------------------
// dma_timing_ctrl_mc
// Multi-channel 8237-style DMA timing controller. It arbitrates among the
// per-channel requests using fixed or rotating priority, runs the
// SI/S0..S4 bus cycle, keeps the current address/count per channel, and
// flags terminal count (with optional auto-initialise).
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   dreq, ch_en       per-channel request / software enable
//   ch_mode           6 bits per channel: [1:0] type, [2] autoinit,
//                     [3] addr decrement, [5:4] demand/single/block
//   cmd_rot_pri       rotating (1) or fixed (0) priority
//   cmd_ext_write     write strobe also asserted in S2
//   base_addr/count   base registers per channel
//   ld_ch             pulse: load current regs from base, clear TC state
//   hlda, eop_n_in    hold acknowledge, external end-of-process (low)
//   hrq, aen, adstb   hold request, address enable, address strobe
//   dack              one-hot acknowledge of the active channel
//   ior_n..memw_n     active-low bus strobes
//   eop_n_out         terminal-count pulse in S4 (low)
//   addr              current address of the active channel
//   tc_status, busy   sticky TC flags, FSM not idle
// ---------------------------------------------------------------------------
module dma_timing_ctrl_mc #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int CW  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH-1:0]    dreq,
    input  logic [NCH-1:0]    ch_en,
    input  logic [6*NCH-1:0]  ch_mode,
    input  logic              cmd_rot_pri,
    input  logic              cmd_ext_write,
    input  logic [AW*NCH-1:0] base_addr,
    input  logic [CW*NCH-1:0] base_count,
    input  logic [NCH-1:0]    ld_ch,
    input  logic              hlda,
    input  logic              eop_n_in,
    output logic              hrq,
    output logic              aen,
    output logic              adstb,
    output logic [NCH-1:0]    dack,
    output logic              ior_n,
    output logic              iow_n,
    output logic              memr_n,
    output logic              memw_n,
    output logic              eop_n_out,
    output logic [AW-1:0]     addr,
    output logic [NCH-1:0]    tc_status,
    output logic              busy
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [5:0] {
        SI = 6'b000001,
        S0 = 6'b000010,
        S1 = 6'b000100,
        S2 = 6'b001000,
        S3 = 6'b010000,
        S4 = 6'b100000
    } state_t;

    state_t                   r_state;
    logic [CHW-1:0]           r_ch;
    logic [CHW-1:0]           r_last;
    logic [NCH-1:0][AW-1:0]   r_addr;
    logic [NCH-1:0][CW-1:0]   r_cnt;
    logic [NCH-1:0]           r_tc;
    logic [NCH-1:0]           r_mask;
    logic                     r_eop;

    logic [NCH-1:0]  w_valid;
    logic            w_any;
    logic [CHW-1:0]  w_win;
    logic [CHW-1:0]  w_cand;
    logic [5:0]      w_mode;
    logic [1:0]      w_type;
    logic            w_auto;
    logic            w_dec;
    logic [1:0]      w_xfer;
    logic [AW-1:0]   w_cur_addr;
    logic [CW-1:0]   w_cur_cnt;
    logic [AW-1:0]   w_base_a;
    logic [CW-1:0]   w_base_c;
    logic            w_tc;
    logic            w_term;
    logic            w_act;
    logic            w_wr;
    logic            w_rd;
    logic            w_rd_on;
    logic            w_wr_on;
    state_t          w_s4_next;

    assign w_valid = dreq & ch_en & ~r_mask;
    assign w_any   = |w_valid;

    // Walk candidates from lowest to highest priority so the last hit wins.
    // Rotating: candidate k slots after the last serviced channel; k = NCH
    // is the last serviced channel itself (lowest priority).
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_cand = cmd_rot_pri ? CHW'((int'(r_last) + k) % NCH) : CHW'(k - 1);
            if (w_valid[w_cand]) w_win = w_cand;
        end
    end

    assign w_mode     = ch_mode[int'(r_ch)*6 +: 6];
    assign w_type     = w_mode[1:0];
    assign w_auto     = w_mode[2];
    assign w_dec      = w_mode[3];
    assign w_xfer     = w_mode[5:4];
    assign w_cur_addr = r_addr[r_ch];
    assign w_cur_cnt  = r_cnt[r_ch];
    assign w_base_a   = base_addr[int'(r_ch)*AW +: AW];
    assign w_base_c   = base_count[int'(r_ch)*CW +: CW];

    // Count of zero going into the S4 update is the last transfer.
    assign w_tc   = (w_cur_cnt == '0);
    assign w_term = w_tc | r_eop;

    always_comb begin
        w_s4_next = SI;
        if (!w_term && hlda) begin
            case (w_xfer)
                2'b10:   w_s4_next = S1;
                2'b00:   w_s4_next = dreq[r_ch] ? S1 : SI;
                default: w_s4_next = SI;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= SI;
            r_ch    <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_tc    <= '0;
            r_mask  <= '0;
            r_eop   <= 1'b0;
        end else begin
            case (r_state)
                SI: if (w_any) begin
                    r_ch    <= w_win;
                    r_state <= S0;
                end
                S0: if (hlda) r_state <= S1;
                S1: r_state <= S2;
                S2: r_state <= S3;
                S3: r_state <= S4;
                S4: begin
                    r_eop   <= 1'b0;
                    r_state <= w_s4_next;
                    if (w_s4_next == SI) r_last <= r_ch;
                    if (w_term) begin
                        r_tc[r_ch] <= 1'b1;
                        if (!w_auto) r_mask[r_ch] <= 1'b1;
                    end
                    if (w_term && w_auto) begin
                        r_addr[r_ch] <= w_base_a;
                        r_cnt[r_ch]  <= w_base_c;
                    end else begin
                        r_addr[r_ch] <= w_dec ? w_cur_addr - AW'(1) : w_cur_addr + AW'(1);
                        r_cnt[r_ch]  <= w_cur_cnt - CW'(1);
                    end
                end
                default: r_state <= SI;
            endcase

            // External EOP only counts while the bus cycle is in flight.
            if ((r_state == S1 || r_state == S2 || r_state == S3) && !eop_n_in)
                r_eop <= 1'b1;

            // Software load comes last so it overrides a same-cycle S4 update.
            for (int c = 0; c < NCH; c++) begin
                if (ld_ch[c]) begin
                    r_addr[c] <= base_addr[c*AW +: AW];
                    r_cnt[c]  <= base_count[c*CW +: CW];
                    r_tc[c]   <= 1'b0;
                    r_mask[c] <= 1'b0;
                end
            end
        end
    end

    // Moore decode from state and latched channel.
    assign w_act   = (r_state == S1) || (r_state == S2) || (r_state == S3) || (r_state == S4);
    assign w_wr    = (w_type == 2'b01);
    assign w_rd    = (w_type == 2'b10);
    assign w_rd_on = (r_state == S2) || (r_state == S3);
    assign w_wr_on = (r_state == S3) || ((r_state == S2) && cmd_ext_write);

    assign busy      = (r_state != SI);
    assign hrq       = (r_state != SI);
    assign aen       = w_act;
    assign adstb     = (r_state == S1);
    assign dack      = w_act ? (NCH'(1) << r_ch) : '0;
    assign addr      = w_act ? w_cur_addr : '0;
    assign ior_n     = ~(w_wr & w_rd_on);
    assign memw_n    = ~(w_wr & w_wr_on);
    assign memr_n    = ~(w_rd & w_rd_on);
    assign iow_n     = ~(w_rd & w_wr_on);
    assign eop_n_out = ~((r_state == S4) & w_tc);
    assign tc_status = r_tc;

endmodule

// File: tb/tb_dma_timing_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_dma_timing_ctrl_mc
// Self-checking bench for dma_timing_ctrl_mc. A transaction-level model
// keeps per-channel address/count/TC/mask state and predicts each bus
// cycle's channel, address, strobes and terminal count.
// ---------------------------------------------------------------------------
module tb_dma_timing_ctrl_mc;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int CW  = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NCH-1:0]    dreq, ch_en, ld_ch;
    logic [6*NCH-1:0]  ch_mode;
    logic              cmd_rot_pri, cmd_ext_write, hlda, eop_n_in;
    logic [AW*NCH-1:0] base_addr;
    logic [CW*NCH-1:0] base_count;
    logic              hrq, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n_out, busy;
    logic [NCH-1:0]    dack, tc_status;
    logic [AW-1:0]     addr;

    always #5 CLK = ~CLK;

    dma_timing_ctrl_mc #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
        .CLK(CLK), .RESET(RESET), .dreq(dreq), .ch_en(ch_en), .ch_mode(ch_mode),
        .cmd_rot_pri(cmd_rot_pri), .cmd_ext_write(cmd_ext_write),
        .base_addr(base_addr), .base_count(base_count), .ld_ch(ld_ch),
        .hlda(hlda), .eop_n_in(eop_n_in), .hrq(hrq), .aen(aen), .adstb(adstb),
        .dack(dack), .ior_n(ior_n), .iow_n(iow_n), .memr_n(memr_n), .memw_n(memw_n),
        .eop_n_out(eop_n_out), .addr(addr), .tc_status(tc_status), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_addr [NCH];
    logic [15:0] m_cnt  [NCH];
    logic [15:0] m_ba   [NCH];
    logic [15:0] m_bc   [NCH];
    logic [1:0]  m_type [NCH];
    bit          m_auto [NCH];
    bit          m_dec  [NCH];
    logic [3:0]  m_tc, m_mask;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ior_n, iow_n, memr_n, memw_n} expected in bus phase ph (2 or 3).
    // The source strobe is on in S2 and S3; the sink strobe in S3, plus S2
    // with extended write.
    function automatic logic [3:0] exp_strb(input logic [1:0] t, input int ph);
        bit src_on, dst_on;
        src_on = (ph == 2) || (ph == 3);
        dst_on = (ph == 3) || ((ph == 2) && cmd_ext_write);
        return {!(t == 2'b01 && src_on), !(t == 2'b10 && dst_on),
                !(t == 2'b10 && src_on), !(t == 2'b01 && dst_on)};
    endfunction

    task automatic cfg(input int c, input logic [1:0] t, input bit au, input bit dc,
                       input logic [1:0] xf, input logic [15:0] ba, input logic [15:0] bc);
        m_type[c] = t; m_auto[c] = au; m_dec[c] = dc; m_ba[c] = ba; m_bc[c] = bc;
        ch_mode[6*c +: 6]     = {xf, dc, au, t};
        base_addr[16*c +: 16]  = ba;
        base_count[16*c +: 16] = bc;
    endtask

    task automatic load(input logic [3:0] m);
        ld_ch = m;
        @(negedge CLK);
        ld_ch = '0;
        for (int c = 0; c < NCH; c++)
            if (m[c]) begin
                m_addr[c] = m_ba[c]; m_cnt[c] = m_bc[c]; m_tc[c] = 1'b0; m_mask[c] = 1'b0;
            end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin m_addr[c] = '0; m_cnt[c] = '0; end
        m_tc = '0; m_mask = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, {hrq, aen, adstb, busy}, 4'b0000);
        chk({tag, "_dack"}, dack, 4'b0000);
        chk({tag, "_strb"}, {ior_n, iow_n, memr_n, memw_n, eop_n_out}, 5'b11111);
        chk({tag, "_addr"}, addr, 16'h0000);
        chk({tag, "_tc"}, tc_status, 4'b0000);
    endtask

    task automatic do_reset();
        RESET = 1'b1; dreq = '0; ld_ch = '0; eop_n_in = 1'b1;
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic pulse_req(input int c);
        dreq[c] = 1'b1;
        @(negedge CLK);
        dreq[c] = 1'b0;
    endtask

    // One S1..S4 bus cycle on channel ch. Returns at the S4 sample point.
    task automatic do_xfer(input int ch, input bit drop, input bit eop, input bit ld,
                           output int waited);
        bit         tc;
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        waited = 0;
        @(negedge CLK);
        while (adstb !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge CLK);
        end
        if (adstb !== 1'b1) begin
            chk("xfer_timeout", 1'b0, 1'b1);
            return;
        end
        chk("s1_dack", dack, oh);
        chk("s1_addr", addr, m_addr[ch]);
        chk("s1_ctl", {aen, hrq, busy, ior_n, iow_n, memr_n, memw_n}, 7'b1111111);
        @(negedge CLK);
        chk("s2_strb", {ior_n, iow_n, memr_n, memw_n}, exp_strb(m_type[ch], 2));
        chk("s2_ack", {adstb, aen, dack}, {2'b01, oh});
        if (drop) dreq[ch] = 1'b0;
        if (eop)  eop_n_in = 1'b0;
        @(negedge CLK);
        eop_n_in = 1'b1;
        chk("s3_strb", {ior_n, iow_n, memr_n, memw_n}, exp_strb(m_type[ch], 3));
        @(negedge CLK);
        tc = (m_cnt[ch] == 16'h0000);
        chk("s4_strb", {ior_n, iow_n, memr_n, memw_n}, 4'b1111);
        chk("s4_eop", eop_n_out, !tc);
        chk("s4_dack", dack, oh);
        m_addr[ch] = m_dec[ch] ? m_addr[ch] - 16'd1 : m_addr[ch] + 16'd1;
        m_cnt[ch]  = m_cnt[ch] - 16'd1;
        if (tc || eop) begin
            m_tc[ch] = 1'b1;
            if (m_auto[ch]) begin m_addr[ch] = m_ba[ch]; m_cnt[ch] = m_bc[ch]; end
            else m_mask[ch] = 1'b1;
        end
        if (ld) begin
            ld_ch[ch] = 1'b1;
            @(negedge CLK);
            ld_ch[ch] = 1'b0;
            m_addr[ch] = m_ba[ch]; m_cnt[ch] = m_bc[ch]; m_tc[ch] = 1'b0; m_mask[ch] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int          w, c, n, sel;
        logic [15:0] ba;
        RESET = 1'b1; dreq = '0; ch_en = 4'hF; ld_ch = '0; ch_mode = '0;
        cmd_rot_pri = 1'b0; cmd_ext_write = 1'b0; base_addr = '0; base_count = '0;
        hlda = 1'b0; eop_n_in = 1'b1;
        model_reset();
        do_reset();
        check_idle("reset");

        // Single write on ch2, two requests, second hits TC.
        cfg(2, 2'b01, 1'b0, 1'b0, 2'b01, 16'h1000, 16'd1);
        load(4'b0100);
        dreq[2] = 1'b1;
        @(negedge CLK);
        dreq[2] = 1'b0;
        chk("req_to_hrq", {hrq, aen}, 2'b10);
        repeat (3) begin
            @(negedge CLK);
            chk("s0_wait_hlda", {hrq, adstb}, 2'b10);
        end
        hlda = 1'b1;
        do_xfer(2, 0, 0, 0, w);
        chk("hlda_to_adstb", w, 0);
        @(negedge CLK);
        chk("single_to_si", {busy, hrq}, 2'b00);
        pulse_req(2);
        do_xfer(2, 0, 0, 0, w);
        @(negedge CLK);
        chk("single_tc_status", tc_status, m_tc);
        dreq[2] = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("tc_masked", hrq, 1'b0);
        end
        dreq[2] = 1'b0;

        // Fixed priority, block count 0 on ch0/1/3.
        for (int i = 0; i < NCH; i++) cfg(i, 2'b01, 1'b0, 1'b0, 2'b10, 16'($urandom), 16'd0);
        load(4'b1011);
        dreq = 4'b1011;
        do_xfer(0, 0, 0, 0, w);
        do_xfer(1, 0, 0, 0, w);
        do_xfer(3, 0, 0, 0, w);
        dreq = '0;
        @(negedge CLK);
        chk("fixed_tc_status", tc_status, m_tc);

        // Rotating priority from reset (last serviced = 0).
        do_reset();
        check_idle("reset2");
        cmd_rot_pri = 1'b1;
        load(4'b1011);
        dreq = 4'b1011;
        do_xfer(1, 0, 0, 0, w);
        do_xfer(3, 0, 0, 0, w);
        do_xfer(0, 0, 0, 0, w);
        dreq = '0;
        @(negedge CLK);
        chk("rot_tc_status", tc_status, m_tc);
        cmd_rot_pri = 1'b0;

        // Block, ch1, count 3, decrement from 3.
        cfg(1, 2'b10, 1'b0, 1'b1, 2'b10, 16'h0003, 16'd3);
        load(4'b0010);
        pulse_req(1);
        do_xfer(1, 0, 0, 0, w);
        for (int i = 1; i < 4; i++) begin
            do_xfer(1, 0, 0, 0, w);
            chk("block_b2b", w, 0);
        end
        @(negedge CLK);
        chk("block_end_si", busy, 1'b0);

        // Demand, ch0: request dropped during second transfer.
        cfg(0, 2'b10, 1'b0, 1'b0, 2'b00, 16'h0100, 16'hFFFF);
        load(4'b0001);
        dreq[0] = 1'b1;
        do_xfer(0, 0, 0, 0, w);
        do_xfer(0, 1, 0, 0, w);
        chk("demand_b2b", w, 0);
        @(negedge CLK);
        chk("demand_pause_si", busy, 1'b0);
        dreq[0] = 1'b1;
        do_xfer(0, 1, 0, 0, w);
        chk("demand_resume_addr", m_addr[0], 16'h0103);
        @(negedge CLK);
        chk("demand_tc_none", tc_status[0], 1'b0);

        // Autoinit + extended write, ch3, count 0.
        cmd_ext_write = 1'b1;
        cfg(3, 2'b01, 1'b1, 1'b0, 2'b01, 16'($urandom), 16'd0);
        load(4'b1000);
        pulse_req(3);
        do_xfer(3, 0, 0, 0, w);
        @(negedge CLK);
        chk("auto_tc_status", tc_status, m_tc);
        pulse_req(3);
        do_xfer(3, 0, 0, 0, w);
        cmd_ext_write = 1'b0;

        // External EOP during block count 10 on ch1.
        cfg(1, 2'b01, 1'b0, 1'b0, 2'b10, 16'h2000, 16'd10);
        load(4'b0010);
        pulse_req(1);
        do_xfer(1, 0, 0, 0, w);
        do_xfer(1, 0, 1, 0, w);
        chk("eop_b2b", w, 0);
        @(negedge CLK);
        chk("eop_si", busy, 1'b0);
        chk("eop_tc_status", tc_status, m_tc);
        dreq[1] = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("eop_masked", hrq, 1'b0);
        end
        dreq[1] = 1'b0;

        // Software-disabled channel never requests the bus.
        cfg(0, 2'b01, 1'b0, 1'b0, 2'b01, 16'h0500, 16'd2);
        load(4'b0001);
        ch_en[0] = 1'b0;
        dreq[0] = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("ch_en_mask", hrq, 1'b0);
        end
        dreq[0] = 1'b0;
        ch_en[0] = 1'b1;

        // ld_ch colliding with the S4 update wins.
        cfg(2, 2'b01, 1'b0, 1'b0, 2'b01, 16'($urandom), 16'd5);
        load(4'b0100);
        pulse_req(2);
        do_xfer(2, 0, 0, 1, w);
        pulse_req(2);
        do_xfer(2, 0, 0, 0, w);
        chk("ld_wins_addr", m_addr[2], m_ba[2] + 16'd1);

        // Reset in the middle of S3.
        cfg(2, 2'b10, 1'b0, 1'b0, 2'b10, 16'h4000, 16'd5);
        load(4'b0100);
        pulse_req(2);
        n = 0;
        while (adstb !== 1'b1 && n < 20) begin n++; @(negedge CLK); end
        chk("rst_s1_seen", adstb, 1'b1);
        @(negedge CLK); @(negedge CLK);
        chk("rst_s3_strb", {memr_n, iow_n}, 2'b00);
        RESET = 1'b1;
        @(negedge CLK);
        check_idle("reset_s3");
        RESET = 1'b0;
        model_reset();

        // Randomised block runs.
        for (int it = 0; it < 8; it++) begin
            c   = $urandom_range(0, NCH - 1);
            n   = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            ba  = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
            cmd_ext_write = 1'($urandom_range(0, 1));
            cfg(c, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'b10, ba, 16'(n));
            load(4'b0001 << c);
            dreq[c] = 1'b1;
            for (int i = 0; i <= n; i++) begin
                do_xfer(c, (i == n), 0, 0, w);
                if (i > 0) chk("rnd_b2b", w, 0);
            end
            @(negedge CLK);
            chk("rnd_si", busy, 1'b0);
            chk("rnd_tc_status", tc_status, m_tc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
